rv32i_data_mem: RTL and testbench
=================================

// Module: rv32i_data_mem
// PURPOSE
//  Parametrised RV32I data memory. Successor to the flat byte-array RAM.
//  Four byte-lane banks sit behind a valid/ready request port and give a registered, pulsed response.
//  Loads are sign/zero-extended in the block. Accesses that cross a word boundary are split in
//  hardware or flagged, selected by macro. Sits between the LSU/execute stage and the core's local data store.
// PARAMETERS
//  ADDR_WIDTH   14       byte-address bits decoded; capacity = 2**ADDR_WIDTH bytes
//  WORD_DEPTH   2**(ADDR_WIDTH-2)  words per bank (derived localparam, not overridable)
// PORTS
//  clk            in   1           clock; all state on rising edge
//  rst            in   1           asynchronous, active-high reset
//  req_valid      in   1           request present
//  req_ready      out  1           block can accept; transfer when req_valid & req_ready
//  mem_op         in   mem_op_e    MEM_LOAD / MEM_STORE / other = no-op
//  ram_mask       in   ram_mask_e  RAM_MASK_B/H/W access size; other encodings = W
//  load_unsigned  in   1           1: zero-extend B/H loads; 0: sign-extend
//  addr           in   32          byte address; bits above ADDR_WIDTH ignored
//  wdata          in   32          store data, LSB-aligned (byte in [7:0], half in [15:0])
//  rsp_valid      out  1           one-cycle response pulse, one per accepted request
//  rsp_err        out  1           valid with rsp_valid: access was rejected
//  rdata          out  32          extended load data, valid with rsp_valid
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rdata=0. Memory contents are not reset.
//  - Storage: 4 banks x WORD_DEPTH x 8b with synchronous read and a byte write enable. Bank k holds byte lane k.
//  - Word index = addr[ADDR_WIDTH-1:2] and wraps modulo WORD_DEPTH. offset = addr[1:0]; size = 1/2/4.
//  - crossing = (offset + size > 4). Alignment itself is never an error; only crossing matters.
//  - FSM IDLE -> RESP (non-crossing, or crossing without the split feature). RESP -> IDLE.
//  - FSM IDLE -> SPLIT (crossing with the split feature). SPLIT -> RESP -> IDLE.
//  - req_ready=1 only in IDLE. A request is accepted in IDLE when req_valid=1.
//  - Non-crossing access: banks are accessed in the accept cycle. rsp_valid is asserted the next cycle (latency 1).
//  - Crossing, split: the accept cycle accesses word W (lanes offset..3). SPLIT accesses word W+1 with wrap (lanes 0..rem-1).
//    For a split access rsp_valid is asserted the cycle after SPLIT (latency 2).
//  - Stores: write bytes rotated to their lanes and update only the enabled lanes. A store response has rsp_valid=1, rdata=0.
//  - Loads: gather bytes from the lanes and right-justify them. Then extend per ram_mask and load_unsigned. W ignores load_unsigned.
//  - No-op mem_op: accepted; rsp_valid next cycle with rdata=0, rsp_err=0; no bank write.
//  - rsp_valid has no backpressure; the consumer must take it in that cycle.
//  - Store followed by a load to the same bytes: the load sees the new data, because the write commits at the accept edge.
//  - Reset mid-SPLIT: return to IDLE. Half 1 of a split store persists and half 2 is dropped. No response is produced.
// CONFIGURATION
//  RV32I_MISALIGN_SPLIT_EN defined: crossing accesses are split as above and rsp_err is always 0.
//  RV32I_MISALIGN_SPLIT_EN undefined: a crossing access completes at latency 1 with rsp_err=1 and rdata=0.
//    No bank is written, and SPLIT is unreachable (its logic is excluded).
// STRUCTURE
//  - rv32i package: mem_op_e and ram_mask_e (existing).
//  - rv32i package additions: dmem_state_e {DMEM_IDLE, DMEM_SPLIT, DMEM_RESP}.
//  - rv32i package additions: function ram_mask_size(ram_mask_e) -> 3b byte count.
//  - Sub-module rv32i_dmem_bank: one 8-bit sync-read RAM lane (clk, we, idx, wd, rd), instantiated 4x via generate.
//  - Top level holds the FSM, lane rotate/enable logic, split-half capture registers and the load extender.
// TESTING
//  1. Reset, then W store 0xDEADBEEF @0x10, then W load @0x10 -> rsp 1 cycle after each accept; rdata=0xDEADBEEF, rsp_err=0.
//  2. B load @0x13, signed -> 0xFFFFFFDE. Same with load_unsigned=1 -> 0x000000DE. H load @0x11, signed -> 0xFFFFADBE.
//  3. H store 0x1234 @0x12, then W load @0x10 -> 0x1234BEEF; other bytes unchanged.
//  4. Split enabled: W store 0xA1B2C3D4 @0x1E, then W load @0x1E -> 0xA1B2C3D4; latency 2; req_ready=0 during SPLIT.
//     Disabled: same store -> rsp_err=1, and words 0x1C and 0x20 are unchanged.
//  5. Wrap: W store 0x55667788 @(2**ADDR_WIDTH-2), split enabled -> bytes 0x88,0x77 at top of memory; 0x66,0x55 at bytes 0,1.
//  6. Assert rst during SPLIT of a store -> FSM IDLE, req_ready=1, no rsp_valid; first half present, second half absent.
//  7. Back-to-back requests with req_valid held -> exactly one rsp_valid per accepted request; no requests lost or duplicated.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I types: memory op / access size encodings, data-memory FSM
// states, and byte-lane helpers used by the data memory.
package rv32i_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        RAM_MASK_B = 2'd0,
        RAM_MASK_H = 2'd1,
        RAM_MASK_W = 2'd2
    } ram_mask_e;

    typedef enum logic [1:0] {
        DMEM_IDLE  = 2'd0,
        DMEM_SPLIT = 2'd1,
        DMEM_RESP  = 2'd2
    } dmem_state_e;

    // Byte count of an access; unlisted encodings behave as a word.
    function automatic logic [2:0] ram_mask_size(input ram_mask_e m);
        case (m)
            RAM_MASK_B: ram_mask_size = 3'd1;
            RAM_MASK_H: ram_mask_size = 3'd2;
            default:    ram_mask_size = 3'd4;
        endcase
    endfunction

    // Rotate a word left by whole bytes: data byte i lands in lane (i+sh)%4.
    function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] sh);
        case (sh)
            2'd0:    rotl_bytes = d;
            2'd1:    rotl_bytes = {d[23:0], d[31:24]};
            2'd2:    rotl_bytes = {d[15:0], d[31:16]};
            default: rotl_bytes = {d[7:0],  d[31:8]};
        endcase
    endfunction

    // Inverse of rotl_bytes: lane (i+sh)%4 moves back to byte i.
    function automatic logic [31:0] rotr_bytes(input logic [31:0] d, input logic [1:0] sh);
        case (sh)
            2'd0:    rotr_bytes = d;
            2'd1:    rotr_bytes = {d[7:0],  d[31:8]};
            2'd2:    rotr_bytes = {d[15:0], d[31:16]};
            default: rotr_bytes = {d[23:0], d[31:24]};
        endcase
    endfunction

endpackage

// File: rtl/rv32i_dmem_bank.sv
// One byte lane of the data memory: synchronous read, single write enable.
// Contents are deliberately not reset.
module rv32i_dmem_bank #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wd,
    output logic [7:0]       rd
);

    logic [7:0] mem_q [DEPTH];

    // Write the addressed byte when enabled; always register the old contents out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wd;
        end
        rd <= mem_q[idx];
    end

endmodule

// File: rtl/rv32i_data_mem.sv
// RV32I data memory: four byte-lane banks behind a valid/ready port with a
// one-cycle response pulse. Loads are extended here.
// Build option RV32I_MISALIGN_SPLIT_EN: when defined, accesses that cross a
// word boundary are split over two bank cycles; otherwise they are rejected
// with rsp_err and leave memory untouched.
module rv32i_data_mem
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  mem_op_e     mem_op,
    input  ram_mask_e   ram_mask,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rdata
);

    localparam int IDX_W      = ADDR_WIDTH - 2;
    localparam int WORD_DEPTH = 2 ** IDX_W;

    dmem_state_e      state_q, state_d;
    logic             accept_s;
    logic [1:0]       off_s;
    logic [IDX_W-1:0] idx_s;
    logic [3:0]       size_mask_s;
    logic [7:0]       en_rot_s;
    logic             cross_s;
    logic [31:0]      wrot_s;
    logic             err_d;

    logic             rsp_valid_q, rsp_err_q, uns_q;
    mem_op_e          op_q;
    ram_mask_e        mask_q;
    logic [1:0]       off_q;

    logic [3:0]       bank_we_s;
    logic [IDX_W-1:0] bank_idx_s;
    logic [3:0][7:0]  bank_wd_s;
    logic [3:0][7:0]  bank_rd_s;
    logic [31:0]      lane_s, gath_s, ext_s;
    logic             unused_addr_s;

`ifdef RV32I_MISALIGN_SPLIT_EN
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       en_hi_q;
    logic [31:0]      wrot_q, half1_q;
`endif

    assign accept_s      = req_valid && (state_q == DMEM_IDLE);
    assign off_s         = addr[1:0];
    assign idx_s         = addr[ADDR_WIDTH-1:2];
    assign unused_addr_s = ^addr[31:ADDR_WIDTH];
    assign req_ready     = (state_q == DMEM_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;

    // Lane enables (bits 7:4 spill into the next word) and rotated store data.
    always_comb begin
        case (ram_mask_size(ram_mask))
            3'd1:    size_mask_s = 4'b0001;
            3'd2:    size_mask_s = 4'b0011;
            default: size_mask_s = 4'b1111;
        endcase
        en_rot_s = {4'b0000, size_mask_s} << off_s;
        cross_s  = |en_rot_s[7:4];
        wrot_s   = rotl_bytes(wdata, off_s);
`ifdef RV32I_MISALIGN_SPLIT_EN
        err_d    = 1'b0;
`else
        err_d    = accept_s && cross_s;
`endif
    end

    // Bank port drive: first (or only) half at accept, second half in SPLIT.
    always_comb begin
        bank_idx_s = idx_s;
        bank_wd_s  = wrot_s;
        bank_we_s  = 4'b0000;
        case (state_q)
`ifdef RV32I_MISALIGN_SPLIT_EN
            DMEM_SPLIT: begin
                bank_idx_s = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                bank_wd_s  = wrot_q;
                bank_we_s  = (op_q == MEM_STORE) ? en_hi_q : 4'b0000;
            end
            DMEM_IDLE: begin
                bank_we_s = (accept_s && mem_op == MEM_STORE) ? en_rot_s[3:0] : 4'b0000;
            end
`else
            DMEM_IDLE: begin
                bank_we_s = (accept_s && mem_op == MEM_STORE && !cross_s) ? en_rot_s[3:0] : 4'b0000;
            end
`endif
            default: begin
                bank_we_s = 4'b0000;
            end
        endcase
    end

    // Four byte-lane banks; bank k holds lane k of every word.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        rv32i_dmem_bank #(.DEPTH(WORD_DEPTH), .IDX_W(IDX_W)) u_bank (
            .clk (clk),
            .we  (bank_we_s[k]),
            .idx (bank_idx_s),
            .wd  (bank_wd_s[k]),
            .rd  (bank_rd_s[k])
        );
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE: begin
                if (accept_s) begin
`ifdef RV32I_MISALIGN_SPLIT_EN
                    state_d = cross_s ? DMEM_SPLIT : DMEM_RESP;
`else
                    state_d = DMEM_RESP;
`endif
                end else begin
                    state_d = DMEM_IDLE;
                end
            end
`ifdef RV32I_MISALIGN_SPLIT_EN
            DMEM_SPLIT: state_d = DMEM_RESP;
`endif
            DMEM_RESP:  state_d = DMEM_IDLE;
            default:    state_d = DMEM_IDLE;
        endcase
    end

    // State register, response flags and captured request attributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DMEM_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            op_q        <= MEM_NOP;
            mask_q      <= RAM_MASK_W;
            uns_q       <= 1'b0;
            off_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == DMEM_RESP);
            rsp_err_q   <= err_d;
            if (accept_s) begin
                op_q   <= mem_op;
                mask_q <= ram_mask;
                uns_q  <= load_unsigned;
                off_q  <= off_s;
            end
        end
    end

`ifdef RV32I_MISALIGN_SPLIT_EN
    // Split bookkeeping: second-half word/lanes/data, and first-half read bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            en_hi_q <= 4'b0000;
            wrot_q  <= 32'h0000_0000;
            half1_q <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                idx_q   <= idx_s;
                en_hi_q <= en_rot_s[7:4];
                wrot_q  <= wrot_s;
            end
            if (state_q == DMEM_SPLIT) begin
                half1_q <= bank_rd_s;
            end
        end
    end
`endif

    // Merge lanes, right-justify, extend, and gate onto the response.
    always_comb begin
        lane_s = bank_rd_s;
`ifdef RV32I_MISALIGN_SPLIT_EN
        for (int k = 0; k < 4; k++) begin
            if ((|en_hi_q) && !en_hi_q[k]) begin
                lane_s[8*k +: 8] = half1_q[8*k +: 8];
            end else begin
                lane_s[8*k +: 8] = bank_rd_s[k];
            end
        end
`endif
        gath_s = rotr_bytes(lane_s, off_q);
        case (mask_q)
            RAM_MASK_B: ext_s = uns_q ? {24'h000000, gath_s[7:0]}  : {{24{gath_s[7]}},  gath_s[7:0]};
            RAM_MASK_H: ext_s = uns_q ? {16'h0000,   gath_s[15:0]} : {{16{gath_s[15]}}, gath_s[15:0]};
            default:    ext_s = gath_s;
        endcase
        if (rsp_valid_q && (op_q == MEM_LOAD) && !rsp_err_q) begin
            rdata = ext_s;
        end else begin
            rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_rv32i_data_mem.sv
// Directed self-checking bench for rv32i_data_mem (both split builds).
module tb_rv32i_data_mem;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, load_unsigned;
    mem_op_e     mem_op;
    ram_mask_e   ram_mask;
    logic [31:0] addr, wdata, rdata;
    logic        rsp_valid, rsp_err;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rv32i_data_mem #(.ADDR_WIDTH(14)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_op(mem_op), .ram_mask(ram_mask), .load_unsigned(load_unsigned),
        .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rdata(rdata)
    );

    // One request; reports first response data/err, latency (0 = none), ready one cycle after accept, pulse count.
    task automatic xfer(input mem_op_e op, input ram_mask_e m, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output logic rdy1, output int n);
        rd = 32'h0; er = 1'b0; lat = 0; rdy1 = 1'b1; n = 0;
        @(negedge clk);
        req_valid = 1'b1; mem_op = op; ram_mask = m; load_unsigned = u; addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) rdy1 = req_ready;
            if (rsp_valid) begin
                if (n == 0) begin lat = k; rd = rdata; er = rsp_err; end
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; mem_op = MEM_NOP; ram_mask = RAM_MASK_W;
        load_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0)   begin errors++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (rdata !== 32'h0)    begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er, r1; int lat, n;
        xfer(MEM_STORE, RAM_MASK_W, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, r1, n);
        checks++; if (lat !== 1 || n !== 1) begin errors++; $display("FAIL st_w_lat got=%0d/%0d exp=1/1", lat, n); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL st_w_rsp got=%h/%b exp=0/0", rd, er); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h10, 32'h0, rd, er, lat, r1, n);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ld_w_lat got=%0d exp=1", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL ld_w got=%h/%b exp=deadbeef/0", rd, er); end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd; logic er, r1; int lat, n;
        xfer(MEM_LOAD, RAM_MASK_B, 1'b0, 32'h13, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb got=%h exp=ffffffde", rd); end
        xfer(MEM_LOAD, RAM_MASK_B, 1'b1, 32'h13, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu got=%h exp=000000de", rd); end
        xfer(MEM_LOAD, RAM_MASK_H, 1'b0, 32'h11, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'hFFFFADBE || er !== 1'b0) begin errors++; $display("FAIL lh got=%h/%b exp=ffffadbe/0", rd, er); end
        xfer(MEM_LOAD, RAM_MASK_H, 1'b1, 32'h11, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h0000ADBE) begin errors++; $display("FAIL lhu got=%h exp=0000adbe", rd); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b1, 32'h10, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_uns got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_half_store();
        logic [31:0] rd; logic er, r1; int lat, n;
        xfer(MEM_STORE, RAM_MASK_H, 1'b0, 32'h12, 32'hFFFF1234, rd, er, lat, r1, n);
        checks++; if (er !== 1'b0 || lat !== 1) begin errors++; $display("FAIL sh_rsp got=%b/%0d exp=0/1", er, lat); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h10, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL sh_readback got=%h exp=1234beef", rd); end
        xfer(MEM_LOAD, RAM_MASK_B, 1'b1, 32'h4011, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h000000BE) begin errors++; $display("FAIL hi_addr_ignored got=%h exp=000000be", rd); end
    endtask

    task automatic test_noop();
        logic [31:0] rd; logic er, r1; int lat, n;
        xfer(MEM_NOP, RAM_MASK_W, 1'b0, 32'h10, 32'hFFFFFFFF, rd, er, lat, r1, n);
        checks++; if (lat !== 1 || rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL noop_rsp got=%0d/%h/%b exp=1/0/0", lat, rd, er); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h10, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL noop_nowrite got=%h exp=1234beef", rd); end
    endtask

    task automatic test_cross();
        logic [31:0] rd; logic er, r1; int lat, n;
        xfer(MEM_STORE, RAM_MASK_W, 1'b0, 32'h1C, 32'h11111111, rd, er, lat, r1, n);
        xfer(MEM_STORE, RAM_MASK_W, 1'b0, 32'h20, 32'h22222222, rd, er, lat, r1, n);
        xfer(MEM_STORE, RAM_MASK_W, 1'b0, 32'h1E, 32'hA1B2C3D4, rd, er, lat, r1, n);
`ifdef RV32I_MISALIGN_SPLIT_EN
        checks++; if (lat !== 2 || n !== 1 || er !== 1'b0) begin errors++; $display("FAIL split_st got=%0d/%0d/%b exp=2/1/0", lat, n, er); end
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL split_ready got=%b exp=0", r1); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h1E, 32'h0, rd, er, lat, r1, n);
        checks++; if (lat !== 2 || rd !== 32'hA1B2C3D4) begin errors++; $display("FAIL split_ld got=%0d/%h exp=2/a1b2c3d4", lat, rd); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h1C, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'hC3D41111) begin errors++; $display("FAIL split_w1c got=%h exp=c3d41111", rd); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h20, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h2222A1B2) begin errors++; $display("FAIL split_w20 got=%h exp=2222a1b2", rd); end
        xfer(MEM_LOAD, RAM_MASK_H, 1'b0, 32'h1F, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'hFFFFB2C3 || er !== 1'b0) begin errors++; $display("FAIL split_lh got=%h/%b exp=ffffb2c3/0", rd, er); end
`else
        checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL cross_st got=%0d/%b/%h exp=1/1/0", lat, er, rd); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h1E, 32'h0, rd, er, lat, r1, n);
        checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL cross_ld got=%0d/%b/%h exp=1/1/0", lat, er, rd); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h1C, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL cross_w1c got=%h exp=11111111", rd); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h20, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL cross_w20 got=%h exp=22222222", rd); end
`endif
        xfer(MEM_LOAD, RAM_MASK_H, 1'b1, 32'h1D, 32'h0, rd, er, lat, r1, n);
        checks++; if (er !== 1'b0 || lat !== 1) begin errors++; $display("FAIL misalign_ok got=%b/%0d exp=0/1", er, lat); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er, r1; int lat, n;
        xfer(MEM_STORE, RAM_MASK_W, 1'b0, 32'h3FFC, 32'h99999999, rd, er, lat, r1, n);
        xfer(MEM_STORE, RAM_MASK_W, 1'b0, 32'h0, 32'hAAAAAAAA, rd, er, lat, r1, n);
        xfer(MEM_STORE, RAM_MASK_W, 1'b0, 32'h3FFE, 32'h55667788, rd, er, lat, r1, n);
`ifdef RV32I_MISALIGN_SPLIT_EN
        checks++; if (er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL wrap_st got=%b/%0d exp=0/2", er, lat); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h3FFC, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h77889999) begin errors++; $display("FAIL wrap_top got=%h exp=77889999", rd); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h0, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'hAAAA5566) begin errors++; $display("FAIL wrap_bot got=%h exp=aaaa5566", rd); end
`else
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL wrap_err got=%b exp=1", er); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h3FFC, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h99999999) begin errors++; $display("FAIL wrap_top got=%h exp=99999999", rd); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h0, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'hAAAAAAAA) begin errors++; $display("FAIL wrap_bot got=%h exp=aaaaaaaa", rd); end
`endif
    endtask

    task automatic test_reset_split();
        logic [31:0] rd; logic er, r1; int lat, n, extra;
        xfer(MEM_STORE, RAM_MASK_W, 1'b0, 32'h40, 32'h0, rd, er, lat, r1, n);
        xfer(MEM_STORE, RAM_MASK_W, 1'b0, 32'h44, 32'h0, rd, er, lat, r1, n);
        @(negedge clk);
        req_valid = 1'b1; mem_op = MEM_STORE; ram_mask = RAM_MASK_W; addr = 32'h42; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", req_ready); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got=%b/%b exp=1/0", req_ready, rsp_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL rst_no_rsp got=%0d exp=0", extra); end
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h40, 32'h0, rd, er, lat, r1, n);
`ifdef RV32I_MISALIGN_SPLIT_EN
        checks++; if (rd !== 32'hF00D0000) begin errors++; $display("FAIL rst_half1 got=%h exp=f00d0000", rd); end
`else
        checks++; if (rd !== 32'h00000000) begin errors++; $display("FAIL rst_half1 got=%h exp=00000000", rd); end
`endif
        xfer(MEM_LOAD, RAM_MASK_W, 1'b0, 32'h44, 32'h0, rd, er, lat, r1, n);
        checks++; if (rd !== 32'h00000000) begin errors++; $display("FAIL rst_half2 got=%h exp=00000000", rd); end
    endtask

    task automatic test_back_to_back();
        mem_op_e     ops [6];
        logic [31:0] ad [6], wd [6], ex [6];
        int          sent, got;
        logic        will_acc;
        ops = '{MEM_STORE, MEM_STORE, MEM_STORE, MEM_LOAD, MEM_LOAD, MEM_LOAD};
        ad  = '{32'h80, 32'h84, 32'h88, 32'h80, 32'h84, 32'h88};
        wd  = '{32'h01020304, 32'hA5A5A5A5, 32'h0F0E0D0C, 32'h0, 32'h0, 32'h0};
        ex  = '{32'h0, 32'h0, 32'h0, 32'h01020304, 32'hA5A5A5A5, 32'h0F0E0D0C};
        sent = 0; got = 0; will_acc = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; mem_op = ops[0]; ram_mask = RAM_MASK_W; load_unsigned = 1'b0;
        addr = ad[0]; wdata = wd[0];
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid) begin
                checks++;
                if (got >= 6) begin
                    errors++; $display("FAIL b2b_extra_rsp got=%0d exp=6", got + 1);
                end else if (rdata !== ex[got] || rsp_err !== 1'b0) begin
                    errors++; $display("FAIL b2b_rsp%0d got=%h/%b exp=%h/0", got, rdata, rsp_err, ex[got]);
                end
                got++;
            end
            if (will_acc) begin
                sent++;
                if (sent < 6) begin
                    mem_op = ops[sent]; addr = ad[sent]; wdata = wd[sent];
                end else begin
                    req_valid = 1'b0;
                end
            end
            will_acc = req_valid && req_ready;
            @(negedge clk);
        end
        checks++; if (sent !== 6) begin errors++; $display("FAIL b2b_sent got=%0d exp=6", sent); end
        checks++; if (got !== 6) begin errors++; $display("FAIL b2b_rsp_count got=%0d exp=6", got); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_load_ext();
        test_half_store();
        test_noop();
        test_cross();
        test_wrap();
        test_reset_split();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
